// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul command sequencer: FSM state encoding,
// field layout of the 32-bit host operation word, and the matmul opcode.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    FIN    = 3'd5
  } state_t;

  // Field offsets of a matmul command inside the host operation word.
  localparam int OP_WORD_W      = 32;
  localparam int OPCODE_LSB     = 0;
  localparam int OPCODE_W       = 4;
  localparam int M_TILES_LSB    = 4;
  localparam int K_TILES_LSB    = 8;
  localparam int N_TILES_LSB    = 12;
  localparam int X_PAGE_LSB     = 16;
  localparam int W_PAGE_LSB     = 20;
  localparam int Y_PAGE_LSB     = 24;
  localparam int TRANSPOSE_BIT  = 28;
  localparam int RELU_BIT       = 29;
  localparam int ACCUM_BIT      = 30;

  localparam logic [OPCODE_W-1:0] OPC_MATMUL = 4'hA;

endpackage

// File: rtl/matmul_tile_sequencer_if.sv
// Command, bank-read and result-write signals of the tile sequencer.
// master = the sequencer (drives the read/write streams), slave = host and banks.
interface matmul_tile_sequencer_if #(
  parameter int ARRAY_N = 8,
  parameter int TILE_W  = 4,
  parameter int ADDR_W  = 10,
  parameter int PAGE_W  = 4
) ();
  localparam int ROW_W = $clog2(ARRAY_N);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [TILE_W-1:0] cmd_m_tiles;
  logic [TILE_W-1:0] cmd_k_tiles;
  logic [TILE_W-1:0] cmd_n_tiles;
  logic [PAGE_W-1:0] cmd_x_page;
  logic [PAGE_W-1:0] cmd_w_page;
  logic [PAGE_W-1:0] cmd_y_page;
  logic              cmd_transpose;
  logic              cmd_relu;
  logic              cmd_accum;

  logic              rd_en;
  logic [PAGE_W-1:0] rd_x_page;
  logic [PAGE_W-1:0] rd_w_page;
  logic [ADDR_W-1:0] rd_x_addr;
  logic [ADDR_W-1:0] rd_w_addr;
  logic              acc_clear;

  logic              wr_valid;
  logic              wr_ready;
  logic [PAGE_W-1:0] wr_page;
  logic [ADDR_W-1:0] wr_addr;
  logic [ROW_W-1:0]  wr_row;
  logic              wr_relu;
  logic              wr_accum;

  modport master (
    input  cmd_valid, cmd_m_tiles, cmd_k_tiles, cmd_n_tiles,
           cmd_x_page, cmd_w_page, cmd_y_page,
           cmd_transpose, cmd_relu, cmd_accum, wr_ready,
    output cmd_ready, rd_en, rd_x_page, rd_w_page, rd_x_addr, rd_w_addr,
           acc_clear, wr_valid, wr_page, wr_addr, wr_row, wr_relu, wr_accum
  );

  modport slave (
    output cmd_valid, cmd_m_tiles, cmd_k_tiles, cmd_n_tiles,
           cmd_x_page, cmd_w_page, cmd_y_page,
           cmd_transpose, cmd_relu, cmd_accum, wr_ready,
    input  cmd_ready, rd_en, rd_x_page, rd_w_page, rd_x_addr, rd_w_addr,
           acc_clear, wr_valid, wr_page, wr_addr, wr_row, wr_relu, wr_accum
  );
endinterface

// File: rtl/matmul_addr_gen.sv
// Tile loop counters (m outer, n middle, k inner, b beat) and the X/W/Y
// address registers. Addresses advance by increment and base reload only.
module matmul_addr_gen #(
  parameter int ARRAY_N = 8,
  parameter int TILE_W  = 4,
  parameter int ADDR_W  = 10,
  parameter int ROW_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TILE_W-1:0] m_tiles,
  input  logic [TILE_W-1:0] k_tiles,
  input  logic [TILE_W-1:0] n_tiles,
  input  logic              transpose,
  input  logic              rd_step,
  input  logic              wr_step,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] y_addr,
  output logic [ROW_W-1:0]  row,
  output logic              first_beat,
  output logic              last_beat,
  output logic              last_k,
  output logic              last_tile,
  output logic              dim_zero
);
  localparam logic [ADDR_W-1:0] TILE_ROWS = ADDR_W'(ARRAY_N);

  logic [TILE_W-1:0] mt_q, kt_q, nt_q;
  logic [TILE_W-1:0] m_q, k_q, n_q;
  logic [ROW_W-1:0]  b_q;
  logic [ADDR_W-1:0] x_q, x_base_q;
  logic [ADDR_W-1:0] w_q, w_kbase_q, w_nbase_q;
  logic [ADDR_W-1:0] y_q;
  logic              last_n, last_m;
  logic [ADDR_W-1:0] n_stride, w_nbase_nxt, w_kbase_nxt;

  assign last_beat   = (b_q == ROW_W'(ARRAY_N - 1));
  assign last_k      = (k_q == kt_q - TILE_W'(1));
  assign last_n      = (n_q == nt_q - TILE_W'(1));
  assign last_m      = (m_q == mt_q - TILE_W'(1));
  assign last_tile   = last_m && last_n;
  assign first_beat  = (k_q == '0) && (b_q == '0);
  assign dim_zero    = (mt_q == '0) || (kt_q == '0) || (nt_q == '0);

  // W row stride between k-blocks when W is stored untransposed: N*ARRAY_N.
  assign n_stride    = ADDR_W'(nt_q) << ROW_W;
  assign w_nbase_nxt = last_n ? '0 : w_nbase_q + TILE_ROWS;
  assign w_kbase_nxt = w_kbase_q + n_stride;

  assign x_addr = x_q;
  assign w_addr = w_q;
  assign y_addr = y_q;
  assign row    = b_q;

  // Advance counters and address registers on each read or accepted write beat.
  // NOTE: every register here has an async reset; none of this is a RAM, so
  // resetting it is cheap and keeps the outputs at 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mt_q      <= '0;
      kt_q      <= '0;
      nt_q      <= '0;
      m_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      x_base_q  <= '0;
      w_q       <= '0;
      w_kbase_q <= '0;
      w_nbase_q <= '0;
      y_q       <= '0;
    end else if (load) begin
      mt_q      <= m_tiles;
      kt_q      <= k_tiles;
      nt_q      <= n_tiles;
      m_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      x_base_q  <= '0;
      w_q       <= '0;
      w_kbase_q <= '0;
      w_nbase_q <= '0;
      y_q       <= '0;
    end else if (rd_step) begin
      b_q <= b_q + ROW_W'(1);
      if (last_beat) k_q <= last_k ? '0 : k_q + TILE_W'(1);
      // X is contiguous across k; replay the row of tiles for each n.
      if (last_beat && last_k && !last_n) x_q <= x_base_q;
      else                                x_q <= x_q + ADDR_W'(1);
      if (last_beat && last_k && last_n)  x_base_q <= x_q + ADDR_W'(1);
      // Transposed W is contiguous across k for one n, restarting each m.
      if (transpose) begin
        w_q <= (last_beat && last_k && last_n) ? '0 : w_q + ADDR_W'(1);
      end else if (last_beat && last_k) begin
        w_nbase_q <= w_nbase_nxt;
        w_kbase_q <= w_nbase_nxt;
        w_q       <= w_nbase_nxt;
      end else if (last_beat) begin
        w_kbase_q <= w_kbase_nxt;
        w_q       <= w_kbase_nxt;
      end else begin
        w_q <= w_q + ADDR_W'(1);
      end
    end else if (wr_step) begin
      // Y rows of consecutive tiles are contiguous in m-major, n-minor order.
      b_q <= b_q + ROW_W'(1);
      y_q <= y_q + ADDR_W'(1);
      if (last_beat) begin
        n_q <= last_n ? '0 : n_q + TILE_W'(1);
        if (last_n) m_q <= m_q + TILE_W'(1);
      end
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Matmul command sequencer: accepts a tiled command, streams bank reads into
// the multiplier, waits out pipeline latency and emits result row writes.
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int ARRAY_N  = 8,
  parameter int TILE_W   = 4,
  parameter int ADDR_W   = 10,
  parameter int PAGE_W   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  matmul_tile_sequencer_if.master        bus,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam int ROW_W   = $clog2(ARRAY_N);
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t             state_q, state_d;
  logic [PAGE_W-1:0]  x_page_q, w_page_q, y_page_q;
  logic               transpose_q, relu_q, accum_q, err_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               accept, rd_step, wr_step;
  logic               first_beat, last_beat, last_k, last_tile, dim_zero;

  assign bus.cmd_ready = enable && (state_q == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.rd_en     = enable && (state_q == STREAM);
  assign rd_step       = bus.rd_en;
  assign bus.acc_clear = bus.rd_en && first_beat;
  assign bus.wr_valid  = enable && (state_q == WRITE);
  assign wr_step       = bus.wr_valid && bus.wr_ready;
  assign done          = enable && (state_q == FIN);
  assign err           = done && err_q;
  assign busy          = (state_q != IDLE);

  assign bus.rd_x_page = x_page_q;
  assign bus.rd_w_page = w_page_q;
  assign bus.wr_page   = y_page_q;
  assign bus.wr_relu   = relu_q;
  assign bus.wr_accum  = accum_q;

  matmul_addr_gen #(
    .ARRAY_N (ARRAY_N),
    .TILE_W  (TILE_W),
    .ADDR_W  (ADDR_W),
    .ROW_W   (ROW_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .m_tiles    (bus.cmd_m_tiles),
    .k_tiles    (bus.cmd_k_tiles),
    .n_tiles    (bus.cmd_n_tiles),
    .transpose  (transpose_q),
    .rd_step    (rd_step),
    .wr_step    (wr_step),
    .x_addr     (bus.rd_x_addr),
    .w_addr     (bus.rd_w_addr),
    .y_addr     (bus.wr_addr),
    .row        (bus.wr_row),
    .first_beat (first_beat),
    .last_beat  (last_beat),
    .last_k     (last_k),
    .last_tile  (last_tile),
    .dim_zero   (dim_zero)
  );

  // State register; frozen while enable is low.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  // Next-state logic for the tile loop.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = dim_zero ? FIN : STREAM;
      STREAM:  if (last_beat && last_k) state_d = DRAIN;
      DRAIN:   if (drain_q == DRAIN_W'(PIPE_LAT - 1)) state_d = WRITE;
      WRITE:   if (bus.wr_ready && last_beat) state_d = last_tile ? FIN : STREAM;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count pipeline drain cycles; cleared in every other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       drain_q <= '0;
    else if (enable) drain_q <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
  end

  // Latch command pages and flags on acceptance; record dimension rejection in LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_page_q    <= '0;
      w_page_q    <= '0;
      y_page_q    <= '0;
      transpose_q <= 1'b0;
      relu_q      <= 1'b0;
      accum_q     <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      x_page_q    <= bus.cmd_x_page;
      w_page_q    <= bus.cmd_w_page;
      y_page_q    <= bus.cmd_y_page;
      transpose_q <= bus.cmd_transpose;
      relu_q      <= bus.cmd_relu;
      accum_q     <= bus.cmd_accum;
      err_q       <= 1'b0;
    end else if (enable && state_q == LOAD) begin
      err_q       <= dim_zero;
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: single and multi-tile commands,
// transposed W, write backpressure, zero dimension, enable freeze and reset abort.
module tb_matmul_tile_sequencer;
  localparam int ARRAY_N  = 8;
  localparam int TILE_W   = 4;
  localparam int ADDR_W   = 10;
  localparam int PAGE_W   = 4;
  localparam int PIPE_LAT = 3;
  localparam int AMASK    = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic reset, enable;
  logic busy, done, err;

  matmul_tile_sequencer_if #(
    .ARRAY_N(ARRAY_N), .TILE_W(TILE_W), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W)
  ) bus ();

  matmul_tile_sequencer #(
    .ARRAY_N(ARRAY_N), .TILE_W(TILE_W), .ADDR_W(ADDR_W),
    .PAGE_W(PAGE_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-run trace, indexed by cycles since acceptance (acceptance edge ends cycle 0).
  int rd_x_q[$], rd_w_q[$], rd_cyc_q[$], clr_q[$];
  int wr_a_q[$], wr_r_q[$], wr_cyc_q[$], frz_q[$];
  int rel, done_rel, done_cnt, err_cnt, err_done_cnt, wv_cnt, wv3_cnt;

  task automatic run_cmd(input int m, input int k, input int n, input bit tr,
                         input int en_off_at, input int stall_addr,
                         input int reset_at, input int budget);
    int stall_left;
    stall_left = 5;
    rd_x_q.delete(); rd_w_q.delete(); rd_cyc_q.delete(); clr_q.delete();
    wr_a_q.delete(); wr_r_q.delete(); wr_cyc_q.delete(); frz_q.delete();
    done_rel = -1; done_cnt = 0; err_cnt = 0; err_done_cnt = 0; wv_cnt = 0; wv3_cnt = 0;
    @(negedge clk);
    bus.cmd_m_tiles   = TILE_W'(m);
    bus.cmd_k_tiles   = TILE_W'(k);
    bus.cmd_n_tiles   = TILE_W'(n);
    bus.cmd_x_page    = 4'h5;
    bus.cmd_w_page    = 4'h6;
    bus.cmd_y_page    = 4'h9;
    bus.cmd_transpose = tr;
    bus.cmd_relu      = 1'b1;
    bus.cmd_accum     = tr;
    bus.cmd_valid     = 1'b1;
    bus.wr_ready      = 1'b1;
    enable            = 1'b1;
    #1 check("cmd_ready_idle", bus.cmd_ready, 1);
    rel = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      rel++;
      bus.cmd_valid = 1'b0;
      enable = !(en_off_at >= 0 && rel >= en_off_at && rel < en_off_at + 4);
      reset  = (reset_at >= 0 && rel >= reset_at && rel < reset_at + 2);
      #1;
      if (stall_addr >= 0 && bus.wr_valid && bus.wr_addr == ADDR_W'(stall_addr) && stall_left > 0) begin
        bus.wr_ready = 1'b0;
        stall_left--;
      end else begin
        bus.wr_ready = 1'b1;
      end
      #1;
      if (bus.rd_en) begin
        if (bus.acc_clear) clr_q.push_back(rd_x_q.size());
        rd_x_q.push_back(int'(bus.rd_x_addr));
        rd_w_q.push_back(int'(bus.rd_w_addr));
        rd_cyc_q.push_back(rel);
      end
      if (bus.wr_valid) begin
        wv_cnt++;
        if (bus.wr_addr == ADDR_W'(3)) wv3_cnt++;
        if (bus.wr_ready) begin
          wr_a_q.push_back(int'(bus.wr_addr));
          wr_r_q.push_back(int'(bus.wr_row));
          wr_cyc_q.push_back(rel);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (err) err_cnt++;
      if (err && done) err_done_cnt++;
      if (!enable) frz_q.push_back(int'(bus.rd_x_addr));
      if (rel == 1 && reset_at != 1) begin
        check("load_busy", busy, 1);
        check("load_cmd_ready", bus.cmd_ready, 0);
      end
      if (reset_at >= 0 && rel == reset_at) begin
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
      end
      if (done_rel >= 0 && rel >= done_rel + 2) break;
    end
    bus.wr_ready = 1'b1;
    enable       = 1'b1;
    reset        = 1'b0;
  endtask

  // Expected streams from the closed-form address equations.
  task automatic compare_model(input string tag, input int m, input int k, input int n, input bit tr);
    int ex[$], ew[$], ey[$];
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        for (int ki = 0; ki < k; ki++)
          for (int b = 0; b < ARRAY_N; b++) begin
            ex.push_back(((mi * k + ki) * ARRAY_N + b) & AMASK);
            ew.push_back((tr ? ((ni * k + ki) * ARRAY_N + b) : ((ki * n + ni) * ARRAY_N + b)) & AMASK);
          end
        for (int b = 0; b < ARRAY_N; b++)
          ey.push_back(((mi * n + ni) * ARRAY_N + b) & AMASK);
      end
    check({tag, "_rd_cnt"}, rd_x_q.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rd_x_q.size(); i++) begin
      check($sformatf("%s_x%0d", tag, i), rd_x_q[i], ex[i]);
      check($sformatf("%s_w%0d", tag, i), rd_w_q[i], ew[i]);
    end
    check({tag, "_wr_cnt"}, wr_a_q.size(), ey.size());
    for (int i = 0; i < ey.size() && i < wr_a_q.size(); i++) begin
      check($sformatf("%s_y%0d", tag, i), wr_a_q[i], ey[i]);
      check($sformatf("%s_row%0d", tag, i), wr_r_q[i], i % ARRAY_N);
    end
    check({tag, "_clr_cnt"}, clr_q.size(), m * n);
    for (int t = 0; t < clr_q.size(); t++)
      check($sformatf("%s_clr%0d", tag, t), clr_q[t], t * k * ARRAY_N);
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1;
    bus.cmd_valid = 1'b0; bus.wr_ready = 1'b1;
    bus.cmd_m_tiles = '0; bus.cmd_k_tiles = '0; bus.cmd_n_tiles = '0;
    bus.cmd_x_page = '0; bus.cmd_w_page = '0; bus.cmd_y_page = '0;
    bus.cmd_transpose = 1'b0; bus.cmd_relu = 1'b0; bus.cmd_accum = 1'b0;
    #2;
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rd_en", bus.rd_en, 0);
    check("reset_wr_valid", bus.wr_valid, 0);
    check("reset_done", done, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single tile, free-flowing writes.
    run_cmd(1, 1, 1, 1'b0, -1, -1, -1, 100);
    compare_model("t111", 1, 1, 1, 1'b0);
    check("t111_done_at", done_rel, 21);
    check("t111_err", err_cnt, 0);
    check("t111_rd_first", rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, 2);
    check("t111_rd_last", rd_cyc_q.size() > 7 ? rd_cyc_q[7] : -1, 9);
    check("t111_wr_first", wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1, 13);
    check("t111_wr_last", wr_cyc_q.size() > 7 ? wr_cyc_q[7] : -1, 20);
    check("t111_x_page", bus.rd_x_page, 5);
    check("t111_w_page", bus.rd_w_page, 6);
    check("t111_y_page", bus.wr_page, 9);
    check("t111_relu", bus.wr_relu, 1);
    check("t111_accum", bus.wr_accum, 0);
    check("t111_idle", busy, 0);

    // Multi-tile M=2, K=3, N=2.
    run_cmd(2, 3, 2, 1'b0, -1, -1, -1, 400);
    compare_model("t232", 2, 3, 2, 1'b0);
    check("t232_done_at", done_rel, 142);
    check("t232_x72", rd_x_q.size() > 95 ? rd_x_q[72] : -1, 24);
    check("t232_x95", rd_x_q.size() > 95 ? rd_x_q[95] : -1, 47);
    check("t232_w72", rd_w_q.size() > 95 ? rd_w_q[72] : -1, 8);
    check("t232_w80", rd_w_q.size() > 95 ? rd_w_q[80] : -1, 24);
    check("t232_w88", rd_w_q.size() > 95 ? rd_w_q[88] : -1, 40);
    check("t232_w95", rd_w_q.size() > 95 ? rd_w_q[95] : -1, 47);
    check("t232_y24", wr_a_q.size() > 24 ? wr_a_q[24] : -1, 24);

    // Same command with transposed W.
    run_cmd(2, 3, 2, 1'b1, -1, -1, -1, 400);
    compare_model("t232t", 2, 3, 2, 1'b1);
    for (int i = 0; i < 24 && i < rd_w_q.size(); i++)
      check($sformatf("t232t_wfirst%0d", i), rd_w_q[i], i);
    check("t232t_accum", bus.wr_accum, 1);

    // Write backpressure: 5 stall cycles at beat 3.
    run_cmd(1, 1, 1, 1'b0, -1, 3, -1, 100);
    compare_model("stall", 1, 1, 1, 1'b0);
    check("stall_done_at", done_rel, 26);
    check("stall_beat3_cycles", wv3_cnt, 6);
    check("stall_wv_cycles", wv_cnt, 13);
    check("stall_wr_first", wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1, 13);

    // Zero inner dimension is rejected.
    run_cmd(1, 0, 1, 1'b0, -1, -1, -1, 20);
    check("kzero_done_at", done_rel, 2);
    check("kzero_done_cnt", done_cnt, 1);
    check("kzero_err_cnt", err_cnt, 1);
    check("kzero_err_with_done", err_done_cnt, 1);
    check("kzero_rd", rd_x_q.size(), 0);
    check("kzero_wv", wv_cnt, 0);

    // Enable low for 4 cycles during STREAM.
    run_cmd(1, 1, 1, 1'b0, 5, -1, -1, 100);
    compare_model("enoff", 1, 1, 1, 1'b0);
    check("enoff_done_at", done_rel, 25);
    check("enoff_frz_cnt", frz_q.size(), 4);
    for (int i = 0; i < frz_q.size(); i++)
      check($sformatf("enoff_frz%0d", i), frz_q[i], 3);
    check("enoff_err", err_cnt, 0);

    // Reset asserted during DRAIN aborts the command.
    run_cmd(1, 1, 1, 1'b0, -1, -1, 11, 40);
    check("rstmid_rd", rd_x_q.size(), 8);
    check("rstmid_wv", wv_cnt, 0);
    check("rstmid_done", done_cnt, 0);
    check("rstmid_busy", busy, 0);

    // The sequencer accepts a fresh command after the abort.
    run_cmd(1, 1, 1, 1'b0, -1, -1, -1, 100);
    compare_model("after_rst", 1, 1, 1, 1'b0);
    check("after_rst_done_at", done_rel, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sequencer.md
Name: matmul_tile_sequencer

Overview:
- Parametrised command sequencer for the systolic matrix unit, generalising the fixed 8x8 single-tile controller to non-square, multi-tile matrices.
- Accepts a matmul command: page selects, dimensions in tiles, and mode flags.
- Drives the bank read stream feeding the multiplier, sequences accumulation across the inner (K) tiles, waits out pipeline latency, then emits per-row write beats with backpressure.
- Sits between the host operation decoder and the register-file banks and multiplier array.

Parameters:
- ARRAY_N, 8: multiplier array edge; one tile is ARRAY_N rows.
- TILE_W, 4: width of each tile-count field; 1..15 tiles per dimension.
- ADDR_W, 10: row address width within a page.
- PAGE_W, 4: page select width; upper 2 bits select the bank, lower 2 bits select the page.
- PIPE_LAT, 3: cycles from the last streamed beat to the first valid result row.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global enable; when low, all state freezes
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_m_tiles, cmd_k_tiles, cmd_n_tiles  in  TILE_W each  X row tiles, inner tiles, W column tiles
- cmd_x_page, cmd_w_page, cmd_y_page  in  PAGE_W each  source and destination pages
- cmd_transpose  in  1  W is stored transposed
- cmd_relu  in  1  apply ReLU on write
- cmd_accum  in  1  add into existing Y instead of overwriting
- rd_en  out  1  bank read beat valid
- rd_x_page, rd_w_page  out  PAGE_W each  latched pages
- rd_x_addr, rd_w_addr  out  ADDR_W each  row addresses
- acc_clear  out  1  clear multiplier accumulators on this beat
- wr_valid  out  1  result row ready for write
- wr_ready  in  1  bank accepts the write
- wr_page  out  PAGE_W  latched Y page
- wr_addr  out  ADDR_W  Y row address
- wr_row  out  log2(ARRAY_N)  result row select into the multiplier output
- wr_relu, wr_accum  out  1 each  latched mode flags
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, concurrent with done, on a rejected command

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE; all outputs 0 except cmd_ready, which follows its equation.
- Reset mid-operation aborts immediately; no further rd/wr beats are issued.
- enable low: counters and state hold. rd_en, wr_valid, done and err are forced 0. cmd_ready is forced 0.
- cmd_ready = enable && state==IDLE.
- A command is accepted on the clock edge where cmd_valid && cmd_ready. All fields are latched on that edge.
- States: IDLE -> LOAD -> STREAM -> DRAIN -> WRITE -> (STREAM for the next tile | FIN) -> IDLE.
- Loop order: m outer, n middle, k inner; b is the beat index 0..ARRAY_N-1.
- LOAD (1 cycle) checks the dimensions. If any dimension is 0: next state is FIN with err=1, and no beats are issued.
- STREAM lasts k_tiles*ARRAY_N cycles with rd_en=1 every cycle.
  - rd_x_addr = (m*K+k)*N_A+b.
  - rd_w_addr = (k*N+n)*N_A+b, or (n*K+k)*N_A+b when transpose is set.
  - acc_clear=1 only on the beat with k=0, b=0.
- DRAIN: exactly PIPE_LAT cycles. No outputs are asserted.
- WRITE: ARRAY_N beats with wr_valid=1.
  - wr_row=b, wr_addr=(m*N+n)*N_A+b.
  - A beat advances only on wr_valid && wr_ready. wr_valid stays high and all wr_* outputs are stable while stalled.
- After the last beat of a tile is accepted: go to STREAM for the next (m,n), or go to FIN if this was the last tile.
- FIN (1 cycle): done=1 (and err if rejected), then IDLE. The next command can be accepted on the cycle after FIN.
- Address arithmetic: all addresses are computed modulo 2^ADDR_W. Wrap is silent; range checking is the host's responsibility.
- Implement addresses with incrementing base registers, not multipliers.

Decomposition:
- Shared package matmul_pkg holds:
  - the state encoding: IDLE, LOAD, STREAM, DRAIN, WRITE, FIN;
  - command field offsets within the 32-bit operation word;
  - the opcode constant for matmul.
- Sub-module matmul_addr_gen holds the m/n/k/b counters and base registers. It outputs the addresses and the last-beat, last-k and last-tile flags. The top-level module holds the FSM and the handshakes.

Test Plan:
- Single tile (1,1,1), wr_ready=1, command accepted at edge 0:
  - LOAD at cycle 1;
  - rd_en cycles 2-9, addresses 0..7, acc_clear only at cycle 2;
  - DRAIN cycles 10-12;
  - wr_valid cycles 13-20, wr_addr 0..7;
  - done at cycle 21.
- Dimensions (2,3,2), no transpose:
  - 4 tiles, each with 24 read beats;
  - tile m=1,n=1 reads x_addr 24..47, w_addr 8..15, 24..31, 40..47;
  - writes y_addr 24..31;
  - exactly 4 acc_clear pulses.
- Same command with cmd_transpose=1: the first tile reads w_addr 0..23 contiguously.
- wr_ready held low for 5 cycles at WRITE beat 3: wr_addr stays at 3 with wr_valid high throughout, then resumes; the total done time is delayed by exactly 5 cycles.
- cmd_k_tiles=0: done and err pulse together 2 cycles after acceptance; rd_en and wr_valid never assert.
- enable dropped for 4 cycles mid-STREAM, and separately reset asserted mid-DRAIN:
  - enable low: no beats and addresses frozen, then the sequence continues without skipping or duplicating beats;
  - reset: immediate IDLE, busy=0, no done pulse.
